// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, 32-step shift-add multiplier, branch
// target, and the EX/MEM pipeline register that feeds the memory-access stage.

module ex_fwd_mux (
  input  logic [4:0]  idx,
  input  logic [31:0] rf_val,
  input  logic        mem_we,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_val,
  input  logic        wb_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_val,
  output logic [31:0] fwd_val
);
  // The younger EX/MEM producer wins over MEM/WB; $0 is never forwarded.
  always_comb begin
    fwd_val = rf_val;
    if (mem_we && (mem_reg != 5'd0) && (mem_reg == idx))
      fwd_val = mem_val;
    else if (wb_we && (wb_reg != 5'd0) && (wb_reg == idx))
      fwd_val = wb_val;
  end
endmodule

module ex_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_read_data1,
  input  logic [31:0] i_read_data2,
  input  logic [31:0] i_sign_ext_imm,
  input  logic [31:0] i_pc_plus4,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [3:0]  i_ALU_op,
  input  logic        i_ALUSrc,
  input  logic        i_RegDst,
  input  logic [1:0]  i_WB_control,
  input  logic [2:0]  i_MEM_control,
  input  logic [4:0]  i_wb_write_reg,
  input  logic        i_wb_regwrite,
  input  logic [31:0] i_wb_data,
  input  logic        i_flush,
  output logic        o_stall,
  output logic [31:0] o_result,
  output logic        o_zero,
  output logic [31:0] o_read_data2,
  output logic [4:0]  o_write_reg,
  output logic [1:0]  o_WB_control,
  output logic [2:0]  o_MEM_control,
  output logic [31:0] o_branch_pc
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic [31:0] rd2;
    logic [4:0]  wreg;
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] bpc;
  } ex_mem_t;

  ex_mem_t            ex_mem;
  mul_state_t         state, state_nxt;
  logic [31:0]        mcand, mplier, acc;
  logic [4:0]         mul_cnt;
  logic [1:0][4:0]    src_idx;
  logic [1:0][31:0]   rf_val, fwd;
  logic [31:0]        op_a, op_b, alu_res, branch_pc;
  logic [4:0]         dest;
  logic               is_mul;

  assign src_idx = {i_rt, i_rs};
  assign rf_val  = {i_read_data2, i_read_data1};

  // Slot 0 resolves rs (operand A), slot 1 resolves rt (operand B / store data).
  for (genvar g = 0; g < 2; g++) begin : g_fwd
    ex_fwd_mux u_fwd (
      .idx     (src_idx[g]),
      .rf_val  (rf_val[g]),
      .mem_we  (ex_mem.wb[0]),
      .mem_reg (ex_mem.wreg),
      .mem_val (ex_mem.result),
      .wb_we   (i_wb_regwrite),
      .wb_reg  (i_wb_write_reg),
      .wb_val  (i_wb_data),
      .fwd_val (fwd[g])
    );
  end

  assign op_a      = fwd[0];
  assign op_b      = i_ALUSrc ? i_sign_ext_imm : fwd[1];
  assign dest      = i_RegDst ? i_rd : i_rt;
  assign is_mul    = (i_ALU_op == OP_MUL);
  assign branch_pc = i_pc_plus4 + {i_sign_ext_imm[29:0], 2'b00};

  always_comb begin
    alu_res = '0;
    case (i_ALU_op)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLT:  alu_res = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      OP_NOR:  alu_res = ~(op_a | op_b);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stall is decoded combinationally so the front end holds in the MUL's first cycle.
  always_comb begin
    state_nxt = state;
    o_stall   = 1'b0;
    case (state)
      IDLE: if (is_mul) begin
        o_stall   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        o_stall = 1'b1;
        if (mul_cnt == 5'd31) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush || i_rst) begin
      o_stall   = 1'b0;
      state_nxt = IDLE;
    end
  end

  // Operands are captured once so forwarding changes during the stall cannot leak in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      mul_cnt <= '0;
    end else if (state == IDLE && is_mul && !i_flush) begin
      mcand   <= op_a;
      mplier  <= op_b;
      acc     <= '0;
      mul_cnt <= '0;
    end else if (state == RUN) begin
      acc     <= acc + (mplier[0] ? mcand : 32'd0);
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      mul_cnt <= mul_cnt + 5'd1;
    end
  end

  // Bubbles clear only the control fields; data fields simply hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_mem <= '0;
    end else if (i_flush) begin
      ex_mem.wb  <= '0;
      ex_mem.mem <= '0;
    end else if (state == DONE) begin
      ex_mem.result <= acc;
      ex_mem.zero   <= (acc == 32'd0);
      ex_mem.rd2    <= fwd[1];
      ex_mem.wreg   <= dest;
      ex_mem.wb     <= i_WB_control;
      ex_mem.mem    <= i_MEM_control;
      ex_mem.bpc    <= branch_pc;
    end else if (o_stall) begin
      ex_mem.wb  <= '0;
      ex_mem.mem <= '0;
    end else begin
      ex_mem.result <= alu_res;
      ex_mem.zero   <= (alu_res == 32'd0);
      ex_mem.rd2    <= fwd[1];
      ex_mem.wreg   <= dest;
      ex_mem.wb     <= i_WB_control;
      ex_mem.mem    <= i_MEM_control;
      ex_mem.bpc    <= branch_pc;
    end
  end

  assign o_result      = ex_mem.result;
  assign o_zero        = ex_mem.zero;
  assign o_read_data2  = ex_mem.rd2;
  assign o_write_reg   = ex_mem.wreg;
  assign o_WB_control  = ex_mem.wb;
  assign o_MEM_control = ex_mem.mem;
  assign o_branch_pc   = ex_mem.bpc;
endmodule

// File: tb/tb_ex_stage.sv
// Directed + randomized bench for ex_stage; random phase checks against an
// architectural register-file model with a two-deep producer history.

module tb_ex_stage;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_read_data1, i_read_data2, i_sign_ext_imm, i_pc_plus4;
  logic [4:0]  i_rs, i_rt, i_rd;
  logic [3:0]  i_ALU_op;
  logic        i_ALUSrc, i_RegDst;
  logic [1:0]  i_WB_control;
  logic [2:0]  i_MEM_control;
  logic [4:0]  i_wb_write_reg;
  logic        i_wb_regwrite;
  logic [31:0] i_wb_data;
  logic        i_flush;
  logic        o_stall;
  logic [31:0] o_result;
  logic        o_zero;
  logic [31:0] o_read_data2;
  logic [4:0]  o_write_reg;
  logic [1:0]  o_WB_control;
  logic [2:0]  o_MEM_control;
  logic [31:0] o_branch_pc;

  int n_chk = 0;
  int n_fail = 0;

  ex_stage dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_read_data1(i_read_data1), .i_read_data2(i_read_data2),
    .i_sign_ext_imm(i_sign_ext_imm), .i_pc_plus4(i_pc_plus4),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
    .i_ALU_op(i_ALU_op), .i_ALUSrc(i_ALUSrc), .i_RegDst(i_RegDst),
    .i_WB_control(i_WB_control), .i_MEM_control(i_MEM_control),
    .i_wb_write_reg(i_wb_write_reg), .i_wb_regwrite(i_wb_regwrite), .i_wb_data(i_wb_data),
    .i_flush(i_flush), .o_stall(o_stall), .o_result(o_result), .o_zero(o_zero),
    .o_read_data2(o_read_data2), .o_write_reg(o_write_reg),
    .o_WB_control(o_WB_control), .o_MEM_control(o_MEM_control), .o_branch_pc(o_branch_pc)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input logic alusrc, input logic [31:0] imm, input logic regdst,
                       input logic [1:0] wb, input logic [2:0] mem);
    i_ALU_op = op; i_rs = rs; i_rt = rt; i_rd = rd;
    i_read_data1 = a; i_read_data2 = b; i_ALUSrc = alusrc; i_sign_ext_imm = imm;
    i_RegDst = regdst; i_WB_control = wb; i_MEM_control = mem;
  endtask

  task automatic wb_src(input logic we, input logic [4:0] r, input logic [31:0] d);
    i_wb_regwrite = we; i_wb_write_reg = r; i_wb_data = d;
  endtask

  // Reference model state for the random phase
  logic [31:0] arch [32];
  logic        h1_w, h2_w;
  logic [4:0]  h1_d, h2_d;
  logic [31:0] h1_r, h2_r;
  logic [3:0]  op_tab [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0101};

  initial begin
    int stall_cycles, bubbles;
    i_rst = 1'b1; i_flush = 1'b0; i_pc_plus4 = '0;
    instr(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000);
    wb_src(0, 0, 0);
    tick(); tick();
    i_rst = 1'b0;

    // Reset abandons a multiply in flight
    instr(4'b1000, 1, 2, 3, 32'd5, 32'd7, 0, 0, 1, 2'b01, 3'b000);
    #1; chk("mul_start_stall", o_stall, 1);
    repeat (5) tick();
    i_rst = 1'b1;
    tick(); tick();
    chk("rst_result", o_result, 0);
    chk("rst_zero", o_zero, 0);
    chk("rst_ctrl", {o_WB_control, o_MEM_control, o_write_reg}, 0);
    chk("rst_rd2_bpc", o_read_data2 | o_branch_pc, 0);
    chk("rst_stall", o_stall, 0);
    i_rst = 1'b0;
    instr(4'b0010, 1, 2, 5, 32'd3, 32'd4, 0, 0, 1, 2'b01, 3'b000);
    #1; chk("post_rst_stall", o_stall, 0);
    tick();
    chk("post_rst_add", o_result, 7);
    chk("post_rst_wreg", o_write_reg, 5);

    // MEM forwarding, MEM over WB priority, $0 never forwarded
    instr(4'b0010, 4, 3, 1, 32'd5, 32'd6, 0, 0, 1, 2'b01, 3'b000);
    tick(); chk("add_5_6", o_result, 11);
    instr(4'b0110, 1, 3, 2, 32'd0, 32'd6, 1, 32'd1, 1, 2'b01, 3'b000);
    tick(); chk("fwd_mem_sub", o_result, 10);
    instr(4'b0010, 4, 3, 1, 32'd5, 32'd6, 0, 0, 1, 2'b01, 3'b000);
    tick();
    instr(4'b0110, 1, 3, 2, 32'd0, 32'd6, 1, 32'd1, 1, 2'b01, 3'b000);
    wb_src(1, 1, 32'd99);
    tick(); chk("fwd_mem_prio", o_result, 10);
    wb_src(0, 0, 0);
    instr(4'b0010, 4, 3, 0, 32'd5, 32'd6, 0, 0, 1, 2'b01, 3'b000);
    tick(); chk("write_r0_wreg", o_write_reg, 0);
    instr(4'b0110, 0, 0, 2, 32'd0, 32'd0, 0, 0, 1, 2'b01, 3'b000);
    wb_src(1, 0, 32'd55);
    tick(); chk("no_fwd_r0", o_result, 0);
    chk("no_fwd_r0_zero", o_zero, 1);

    // Store with rt forwarded from WB
    instr(4'b0010, 4, 7, 0, 32'h100, 32'd0, 1, 32'd8, 0, 2'b00, 3'b100);
    wb_src(1, 7, 32'hDEADBEEF);
    tick();
    chk("sw_rd2", o_read_data2, 32'hDEADBEEF);
    chk("sw_mem", o_MEM_control, 3'b100);
    chk("sw_addr", o_result, 32'h108);
    wb_src(0, 0, 0);

    // Multiply: stall length, bubble count, operands immune to later forwarding
    instr(4'b1000, 10, 11, 9, 32'hFFFF_FFFF, 32'd3, 0, 0, 1, 2'b01, 3'b000);
    #1;
    stall_cycles = 0; bubbles = 0;
    while (o_stall && stall_cycles < 40) begin
      stall_cycles++;
      tick();
      if (o_WB_control == 2'b00 && o_MEM_control == 3'b000) bubbles++;
      if (stall_cycles == 1) begin
        i_read_data1 = 32'd0; i_read_data2 = 32'd0;
        wb_src(1, 10, 32'h12345);
      end
      #1;
    end
    chk("mul_stall_cycles", stall_cycles, 33);
    chk("mul_bubbles", bubbles, 33);
    tick();
    chk("mul_result", o_result, 32'hFFFF_FFFD);
    chk("mul_regwrite", o_WB_control, 2'b01);
    chk("mul_wreg", o_write_reg, 9);
    chk("mul_zero", o_zero, 0);
    wb_src(0, 0, 0);
    #1; chk("mul_b2b_stall", o_stall, 1);

    // Flush ten cycles into the back-to-back multiply
    repeat (10) tick();
    chk("mul_pre_flush_stall", o_stall, 1);
    i_flush = 1'b1;
    #1; chk("flush_stall", o_stall, 0);
    tick();
    chk("flush_bubble", {o_WB_control, o_MEM_control}, 0);
    i_flush = 1'b0;
    instr(4'b0010, 1, 2, 5, 32'd3, 32'd4, 0, 0, 1, 2'b01, 3'b000);
    #1; chk("post_flush_stall", o_stall, 0);
    tick(); chk("post_flush_add", o_result, 7);

    // Branch target and SLT
    i_pc_plus4 = 32'h100;
    instr(4'b0110, 12, 13, 0, 32'd7, 32'd7, 0, 32'hFFFF_FFFC, 0, 2'b00, 3'b001);
    tick();
    chk("br_pc", o_branch_pc, 32'hF0);
    chk("br_zero", o_zero, 1);
    chk("br_mem", o_MEM_control, 3'b001);
    instr(4'b0111, 12, 13, 0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 2'b00, 3'b000);
    tick(); chk("slt_neg", o_result, 1);
    instr(4'b0111, 12, 13, 0, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 2'b00, 3'b000);
    tick(); chk("slt_pos", o_result, 0);
    instr(4'b0011, 12, 13, 0, 32'd1, 32'd2, 0, 0, 0, 2'b00, 3'b000);
    tick(); chk("bad_op", o_result, 0);

    // Random phase: operands come from the architectural register model
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    for (int r = 0; r < 32; r++) arch[r] = (r == 0) ? 32'd0 : $urandom;
    h1_w = 0; h2_w = 0; h1_d = 0; h2_d = 0; h1_r = 0; h2_r = 0;
    for (int k = 0; k < 200; k++) begin
      logic [4:0]  rs, rt, rd, dst;
      logic [3:0]  op;
      logic [31:0] a, b_rt, b, imm, pc, res;
      logic        src, rdst, stale_a, stale_b;
      logic [1:0]  wb;
      logic [2:0]  mem;
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      op = op_tab[$urandom_range(0, 6)];
      src = 1'($urandom); rdst = 1'($urandom);
      wb = 2'($urandom); mem = 3'($urandom);
      imm = $urandom; pc = $urandom;
      a = arch[rs]; b_rt = arch[rt];
      b = src ? imm : b_rt;
      case (op)
        4'b0000: res = a & b;
        4'b0001: res = a | b;
        4'b0010: res = a + b;
        4'b0110: res = a - b;
        4'b0111: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'b1100: res = ~(a | b);
        default: res = 32'd0;
      endcase
      dst = rdst ? rd : rt;
      // Registers produced by either of the two older in-flight ops are stale in the file
      stale_a = (rs != 0) && ((h1_w && h1_d == rs) || (h2_w && h2_d == rs));
      stale_b = (rt != 0) && ((h1_w && h1_d == rt) || (h2_w && h2_d == rt));
      instr(op, rs, rt, rd, stale_a ? $urandom : a, stale_b ? $urandom : b_rt,
            src, imm, rdst, wb, mem);
      i_pc_plus4 = pc;
      wb_src(h2_w, h2_d, h2_r);
      tick();
      chk("rnd_result", o_result, res);
      chk("rnd_zero", o_zero, (res == 0));
      chk("rnd_rd2", o_read_data2, b_rt);
      chk("rnd_wreg", o_write_reg, dst);
      chk("rnd_ctrl", {o_WB_control, o_MEM_control}, {wb, mem});
      chk("rnd_bpc", o_branch_pc, pc + imm * 4);
      if (wb[0] && dst != 0) arch[dst] = res;
      h2_w = h1_w; h2_d = h1_d; h2_r = h1_r;
      h1_w = wb[0]; h1_d = dst; h1_r = res;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
